// File: rtl/symm_pkg.sv
// Shared types and fixed-point helpers for the symmetric-orthogonalisation square stage.
package symm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Fixed-point 1.0 for a given number of fractional bits.
    function automatic longint one_fx(input int frac);
        return longint'(1) <<< frac;
    endfunction

    // Largest positive value of a w-bit signed element.
    function automatic longint maxpos_fx(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    // Bit offset of element (r,c) in a row-major flat n x n bus of w-bit elements.
    function automatic int elem_lsb(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/symm_sq_lane.sv
// Combinational fixed-point squarer: q = sat_or_wrap((b*b + rnd) >>> FRAC).
module symm_sq_lane
    import symm_pkg::*;
#(
    parameter int W     = 26,
    parameter int FRAC  = 13,
    parameter int ROUND = 0,
    parameter int SAT   = 1
) (
    input  logic [W-1:0] b_i,
    output logic [W-1:0] q_o
);

    localparam logic [2*W-1:0] RND_K = (ROUND != 0) ? (2*W)'(one_fx(FRAC) >>> 1) : '0;
    localparam logic [2*W-1:0] MAX_K = (2*W)'(maxpos_fx(W));

    logic signed [2*W-1:0] b_ext;
    logic        [2*W-1:0] prod;
    logic        [2*W-1:0] sum;
    logic        [2*W-1:0] shifted;

    // A square is never negative and even (-2^(W-1))^2 fits below the 2W-bit sign bit,
    // so everything after the multiply can stay unsigned.
    always_comb begin
        b_ext   = {{W{b_i[W-1]}}, b_i};
        prod    = b_ext * b_ext;
        sum     = prod + RND_K;
        shifted = sum >> FRAC;
        if ((SAT != 0) && (shifted > MAX_K)) begin
            q_o = MAX_K[W-1:0];
        end else begin
            q_o = shifted[W-1:0];
        end
    end

endmodule

// File: rtl/symm_sq_engine.sv
// Time-multiplexed element-wise square of an N x N matrix over LANES shared squarers.
module symm_sq_engine
    import symm_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 26,
    parameter int FRAC  = 13,
    parameter int LANES = 4,
    parameter int ROUND = 0,
    parameter int SAT   = 1
) (
    input  logic               clk_mul,
    input  logic               rstn_mul,
    input  logic               en_mul,
    input  logic [N*N*W-1:0]   b_flat,
    output logic               busy,
    output logic               done,
    output logic               out_valid,
    output logic [N*N*W-1:0]   w_flat,
    output logic [N*N*W-1:0]   w2_flat
);

    localparam int ELEMS  = N * N;
    localparam int GROUPS = ELEMS / LANES;
    localparam int IDX_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUPS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ELEMS*W-1:0] opbuf_q, opbuf_d;
    logic [ELEMS*W-1:0] w_q, w_d;
    logic [ELEMS*W-1:0] w2_q, w2_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;

    int                 group_base;
    logic [W-1:0]       lane_b [LANES];
    logic [W-1:0]       lane_q [LANES];

    always_comb group_base = int'(idx_q) * LANES;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_b[l] = opbuf_q[elem_lsb((group_base + l) / N, (group_base + l) % N, N, W) +: W];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        symm_sq_lane #(
            .W     (W),
            .FRAC  (FRAC),
            .ROUND (ROUND),
            .SAT   (SAT)
        ) u_lane (
            .b_i (lane_b[l]),
            .q_o (lane_q[l])
        );
    end

    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opbuf_d = opbuf_q;
        w_d     = w_q;
        w2_d    = w2_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (en_mul) begin
                    opbuf_d = b_flat;
                    w_d     = b_flat;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    w2_d[elem_lsb((group_base + l) / N, (group_base + l) % N, N, W) +: W] = lane_q[l];
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand buffer is reset with everything else so no stale matrix survives a reset.
    always_ff @(posedge clk_mul or negedge rstn_mul) begin
        if (!rstn_mul) begin
            state_q <= IDLE;
            idx_q   <= '0;
            opbuf_q <= '0;
            w_q     <= '0;
            w2_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
            state_q <= state_d;
            idx_q   <= idx_d;
            opbuf_q <= opbuf_d;
            w_q     <= w_d;
            w2_q    <= w2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign w_flat    = w_q;
    assign w2_flat   = w2_q;

endmodule
